// File: rtl/ps2_pkg.sv
// Shared scancode constants, key indices, FSM encoding and the scancode-to-key
// lookup used by the PS/2 key sequencer.
package ps2_pkg;

    localparam int NUM_KEYS = 16;
    localparam int KEY_W    = 4;
    localparam int EVT_W    = KEY_W + 1;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_4     = 8'h25;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_T     = 8'h2C;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_P     = 8'h4D;

    localparam logic [KEY_W-1:0] KEY_UP    = 4'd0;
    localparam logic [KEY_W-1:0] KEY_LEFT  = 4'd1;
    localparam logic [KEY_W-1:0] KEY_DOWN  = 4'd2;
    localparam logic [KEY_W-1:0] KEY_RIGHT = 4'd3;
    localparam logic [KEY_W-1:0] KEY_1     = 4'd4;
    localparam logic [KEY_W-1:0] KEY_2     = 4'd5;
    localparam logic [KEY_W-1:0] KEY_3     = 4'd6;
    localparam logic [KEY_W-1:0] KEY_4     = 4'd7;
    localparam logic [KEY_W-1:0] KEY_5     = 4'd8;
    localparam logic [KEY_W-1:0] KEY_T     = 4'd9;
    localparam logic [KEY_W-1:0] KEY_W_    = 4'd10;
    localparam logic [KEY_W-1:0] KEY_A     = 4'd11;
    localparam logic [KEY_W-1:0] KEY_S     = 4'd12;
    localparam logic [KEY_W-1:0] KEY_D     = 4'd13;
    localparam logic [KEY_W-1:0] KEY_R     = 4'd14;
    localparam logic [KEY_W-1:0] KEY_P     = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0_F0
    } ps2_state_e;

    typedef struct packed {
        logic             hit;
        logic [KEY_W-1:0] idx;
    } key_match_t;

    // Arrow codes only count with the E0 prefix; bare they are keypad keys.
    function automatic key_match_t key_match(input logic [7:0] code, input logic ext);
        key_match_t m;
        m.hit = 1'b1;
        m.idx = '0;
        if (ext) begin
            case (code)
                SC_UP:    m.idx = KEY_UP;
                SC_LEFT:  m.idx = KEY_LEFT;
                SC_DOWN:  m.idx = KEY_DOWN;
                SC_RIGHT: m.idx = KEY_RIGHT;
                default:  m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_1:    m.idx = KEY_1;
                SC_2:    m.idx = KEY_2;
                SC_3:    m.idx = KEY_3;
                SC_4:    m.idx = KEY_4;
                SC_5:    m.idx = KEY_5;
                SC_T:    m.idx = KEY_T;
                SC_W:    m.idx = KEY_W_;
                SC_A:    m.idx = KEY_A;
                SC_S:    m.idx = KEY_S;
                SC_D:    m.idx = KEY_D;
                SC_R:    m.idx = KEY_R;
                SC_P:    m.idx = KEY_P;
                default: m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Byte-in / event-out bus of the key sequencer: receiver strobe plus FIFO pop handshake.
interface ps2_key_sequencer_if;
    import ps2_pkg::*;

    logic [7:0]       code_in;
    logic             code_valid;
    logic             event_valid;
    logic [EVT_W-1:0] event_data;
    logic             event_ready;

    modport master (
        output code_in, code_valid, event_ready,
        input  event_valid, event_data
    );

    modport slave (
        input  code_in, code_valid, event_ready,
        output event_valid, event_data
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word fall-through event FIFO with a sticky overflow flag for dropped pushes.
module ps2_event_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         overflow,
    input  logic         clear_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;

    logic w_empty, w_full, w_do_pop, w_do_push, w_drop;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(DEPTH));
    assign w_do_pop  = pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_do_push = push && (!w_full || w_do_pop);
    assign w_drop    = push && !w_do_push;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_do_pop) r_rd <= r_rd + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_drop)              r_ovf <= 1'b1;
            else if (clear_overflow) r_ovf <= 1'b0;
        end
    end

    assign valid    = !w_empty;
    assign dout     = w_empty ? '0 : r_mem[r_rd];
    assign overflow = r_ovf;
endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scancode sequencer: E0/F0 prefix FSM, held-key bitmap, press/release pulses
// and an event FIFO for processor polling.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int EVT_DEPTH      = 4,
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  logic                clock,
    input  logic                reset_n,
    ps2_key_sequencer_if.slave  bus,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                overflow,
    input  logic                clear_overflow
);
    localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;

    ps2_state_e          r_state, w_next;
    logic [TW-1:0]       r_tmo;
    logic [NUM_KEYS-1:0] r_held, r_press, r_release;

    key_match_t          w_m;
    logic                w_ext, w_brk_state, w_key_byte, w_press, w_rel, w_timeout;
    logic [NUM_KEYS-1:0] w_onehot;
    logic [EVT_W-1:0]    w_evt_data;
    logic                w_evt_valid;

    assign w_timeout = (r_state != ST_IDLE) && !bus.code_valid
                    && (r_tmo == TW'(PREFIX_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_tmo   <= '0;
        end else begin
            r_state <= w_next;
            if (bus.code_valid || r_state == ST_IDLE || w_timeout) r_tmo <= '0;
            else                                                   r_tmo <= r_tmo + TW'(1);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ext       = (r_state == ST_GOT_E0) || (r_state == ST_GOT_E0_F0);
        w_brk_state = (r_state == ST_GOT_F0) || (r_state == ST_GOT_E0_F0);
        w_m         = key_match(bus.code_in, w_ext);
        w_key_byte  = 1'b0;
        if (bus.code_valid) begin
            if (bus.code_in == SC_E0) begin
                w_next = ST_GOT_E0;
            end else if (bus.code_in == SC_F0) begin
                if (r_state == ST_IDLE)        w_next = ST_GOT_F0;
                else if (r_state == ST_GOT_E0) w_next = ST_GOT_E0_F0;
            end else begin
                w_next     = ST_IDLE;
                w_key_byte = w_m.hit;
            end
        end else if (w_timeout) begin
            w_next = ST_IDLE;
        end
        w_onehot = NUM_KEYS'(1) << w_m.idx;
        // Typematic repeats of a held key and breaks of an unheld key are silent.
        w_press  = w_key_byte && !w_brk_state && !r_held[w_m.idx];
        w_rel    = w_key_byte &&  w_brk_state &&  r_held[w_m.idx];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_held    <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            if (w_press)    r_held <= r_held | w_onehot;
            else if (w_rel) r_held <= r_held & ~w_onehot;
            r_press   <= w_press ? w_onehot : '0;
            r_release <= w_rel   ? w_onehot : '0;
        end
    end

    ps2_event_fifo #(
        .W     (EVT_W),
        .DEPTH (EVT_DEPTH)
    ) u_fifo (
        .clock          (clock),
        .reset_n        (reset_n),
        .push           (w_press || w_rel),
        .din            ({w_rel, w_m.idx}),
        .pop            (bus.event_ready),
        .dout           (w_evt_data),
        .valid          (w_evt_valid),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    assign bus.event_data  = w_evt_data;
    assign bus.event_valid = w_evt_valid;
    assign key_held        = r_held;
    assign key_press       = r_press;
    assign key_release     = r_release;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer with hand-computed expectations.
module tb_ps2_key_sequencer;
    localparam int PT = 20;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] key_held, key_press, key_release;
    logic        overflow, clear_overflow;
    int          n_chk = 0;
    int          n_fail = 0;

    ps2_key_sequencer_if bus ();

    ps2_key_sequencer #(
        .EVT_DEPTH      (4),
        .PREFIX_TIMEOUT (PT)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus            (bus),
        .key_held       (key_held),
        .key_press      (key_press),
        .key_release    (key_release),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.code_in    = b;
        bus.code_valid = 1'b1;
        @(negedge clock);
        bus.code_valid = 1'b0;
        bus.code_in    = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pop_chk(input string tag, input logic [4:0] exp);
        chk({tag, "_valid"}, {31'd0, bus.event_valid}, 32'd1);
        chk({tag, "_data"}, {27'd0, bus.event_data}, {27'd0, exp});
        bus.event_ready = 1'b1;
        @(negedge clock);
        bus.event_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        bus.code_in     = 8'h00;
        bus.code_valid  = 1'b0;
        bus.event_ready = 1'b0;
        clear_overflow  = 1'b0;
        reset_n         = 1'b0;
        idle(3);
        chk("rst_held", {16'd0, key_held}, 32'h0);
        chk("rst_press", {16'd0, key_press}, 32'h0);
        chk("rst_release", {16'd0, key_release}, 32'h0);
        chk("rst_evalid", {31'd0, bus.event_valid}, 32'h0);
        chk("rst_edata", {27'd0, bus.event_data}, 32'h0);
        chk("rst_ovf", {31'd0, overflow}, 32'h0);
        reset_n = 1'b1;
        idle(1);

        // Key A make then break
        send(8'h1C);
        chk("a_press", {16'd0, key_press}, 32'h0800);
        chk("a_held", {16'd0, key_held}, 32'h0800);
        idle(1);
        chk("a_press_1cyc", {16'd0, key_press}, 32'h0);
        send(8'hF0);
        chk("a_f0_held", {16'd0, key_held}, 32'h0800);
        send(8'h1C);
        chk("a_release", {16'd0, key_release}, 32'h0800);
        chk("a_held0", {16'd0, key_held}, 32'h0);
        idle(1);
        chk("a_release_1cyc", {16'd0, key_release}, 32'h0);
        pop_chk("a_ev0", 5'h0B);
        pop_chk("a_ev1", 5'h1B);
        chk("a_empty", {31'd0, bus.event_valid}, 32'h0);

        // Extended up key, then bare keypad 75
        send(8'hE0); send(8'h75);
        chk("up_press", {16'd0, key_press}, 32'h0001);
        chk("up_held", {16'd0, key_held}, 32'h0001);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_release", {16'd0, key_release}, 32'h0001);
        chk("up_held0", {16'd0, key_held}, 32'h0);
        pop_chk("up_ev0", 5'h00);
        pop_chk("up_ev1", 5'h10);
        send(8'h75);
        chk("kp_press", {16'd0, key_press}, 32'h0);
        chk("kp_held", {16'd0, key_held}, 32'h0);
        chk("kp_evalid", {31'd0, bus.event_valid}, 32'h0);
        send(8'h1C);
        chk("kp_idle_make", {16'd0, key_press}, 32'h0800);
        send(8'hF0); send(8'h1C);
        pop_chk("kp_ev0", 5'h0B);
        pop_chk("kp_ev1", 5'h1B);

        // Typematic repeat of W
        send(8'h1D);
        chk("rep_press0", {16'd0, key_press}, 32'h0400);
        send(8'h1D);
        chk("rep_press1", {16'd0, key_press}, 32'h0);
        send(8'h1D);
        chk("rep_press2", {16'd0, key_press}, 32'h0);
        chk("rep_held", {16'd0, key_held}, 32'h0400);
        pop_chk("rep_ev", 5'h0A);
        chk("rep_single", {31'd0, bus.event_valid}, 32'h0);
        send(8'hF0); send(8'h1D);
        pop_chk("rep_rel", 5'h1A);

        // Prefix timeout boundary: PT-1 idle cycles keeps E0, PT drops it
        send(8'hE0); idle(PT - 1); send(8'h75);
        chk("tmo_in_time", {16'd0, key_held}, 32'h0001);
        send(8'hE0); send(8'hF0); send(8'h75);
        pop_chk("tmo_ev0", 5'h00);
        pop_chk("tmo_ev1", 5'h10);
        send(8'hE0); idle(PT); send(8'h75);
        chk("tmo_expired_held", {16'd0, key_held}, 32'h0);
        chk("tmo_expired_press", {16'd0, key_press}, 32'h0);
        chk("tmo_expired_ev", {31'd0, bus.event_valid}, 32'h0);

        // Overflow with six makes into a 4-deep FIFO
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        chk("ovf_full_no_ovf", {31'd0, overflow}, 32'h0);
        send(8'h2E);
        chk("ovf_set", {31'd0, overflow}, 32'h1);
        send(8'h2C);
        chk("ovf_held", {16'd0, key_held}, 32'h03F0);
        chk("ovf_head", {27'd0, bus.event_data}, 32'h04);
        bus.event_ready = 1'b1;
        send(8'h1D);
        bus.event_ready = 1'b0;
        chk("pp_press", {16'd0, key_press}, 32'h0400);
        chk("pp_held", {16'd0, key_held}, 32'h07F0);
        chk("pp_ovf", {31'd0, overflow}, 32'h1);
        pop_chk("pp_ev0", 5'h05);
        pop_chk("pp_ev1", 5'h06);
        pop_chk("pp_ev2", 5'h07);
        pop_chk("pp_ev3", 5'h0A);
        chk("pp_empty", {31'd0, bus.event_valid}, 32'h0);
        clear_overflow = 1'b1;
        idle(1);
        clear_overflow = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'h0);
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2D);
        clear_overflow = 1'b1;
        send(8'h4D);
        clear_overflow = 1'b0;
        chk("ovf_drop_wins", {31'd0, overflow}, 32'h1);
        chk("ovf_held_all", {16'd0, key_held}, 32'hFFF0);

        // Asynchronous reset between F0 and 1C
        do_reset();
        chk("rst2_held", {16'd0, key_held}, 32'h0);
        chk("rst2_ovf", {31'd0, overflow}, 32'h0);
        send(8'h1C);
        chk("mid_held", {16'd0, key_held}, 32'h0800);
        send(8'hF0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_held", {16'd0, key_held}, 32'h0);
        chk("mid_rst_press", {16'd0, key_press}, 32'h0);
        chk("mid_rst_release", {16'd0, key_release}, 32'h0);
        chk("mid_rst_evalid", {31'd0, bus.event_valid}, 32'h0);
        chk("mid_rst_edata", {27'd0, bus.event_data}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(1);
        send(8'h1C);
        chk("post_rst_press", {16'd0, key_press}, 32'h0800);
        chk("post_rst_held", {16'd0, key_held}, 32'h0800);
        chk("post_rst_rel", {16'd0, key_release}, 32'h0);
        chk("post_rst_ev", {27'd0, bus.event_data}, 32'h0B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
